// File: rtl/penalty_round_ctl.sv
// Penalty round sequencer: CPU shot targeting, frame-timed aim/flight/result phases, save judging and scoring.
// Optional build macro MISS_SHOTS_EN enables deliberate off-target (missed) shots.
module penalty_round_ctl #(
    parameter int unsigned SHOTS_PER_MATCH = 5,
    parameter int unsigned AIM_FRAMES      = 60,
    parameter int unsigned FLIGHT_FRAMES   = 30,
    parameter int unsigned RESULT_FRAMES   = 90,
    parameter int unsigned X_MIN           = 256,
    parameter int unsigned Y_MIN           = 160,
    parameter int unsigned GLOVE_HALF_W    = 64,
    parameter int unsigned GLOVE_HALF_H    = 48,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [11:0] shot_xpos,
    output logic [11:0] shot_ypos,
    output logic        ball_launch,
    output logic        ball_active,
    output logic        goal_pulse,
    output logic        save_pulse,
    output logic        result_show,
    output logic [3:0]  goals,
    output logic [3:0]  saves,
    output logic [3:0]  shot_num,
    output logic        match_over,
    output logic        player_won
);

    localparam int unsigned FCNT_W = 16;
    localparam int unsigned DIFF_W = 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AIM,
        S_FLIGHT,
        S_JUDGE,
        S_RESULT,
        S_DONE
    } state_t;

    state_t              state, state_d;
    logic [FCNT_W-1:0]   fcnt;
    logic [15:0]         lfsr, lfsr_next;
    logic [11:0]         glove_x, glove_y;
    logic [DIFF_W-1:0]   dx, dy, adx, ady;
    logic                in_reach, judge_save;
    logic                aim_entry;
`ifdef MISS_SHOTS_EN
    logic                shot_miss;
`endif

    // Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1
    assign lfsr_next = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};

    // Glove distance in 13-bit two's complement so no difference wraps
    always_comb begin
        dx       = DIFF_W'({1'b0, glove_x}) - DIFF_W'({1'b0, shot_xpos});
        dy       = DIFF_W'({1'b0, glove_y}) - DIFF_W'({1'b0, shot_ypos});
        adx      = dx[DIFF_W-1] ? (DIFF_W'(0) - dx) : dx;
        ady      = dy[DIFF_W-1] ? (DIFF_W'(0) - dy) : dy;
        in_reach = (adx <= DIFF_W'(GLOVE_HALF_W)) && (ady <= DIFF_W'(GLOVE_HALF_H));
`ifdef MISS_SHOTS_EN
        judge_save = in_reach | shot_miss;
`else
        judge_save = in_reach;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (start) state_d = S_AIM;
            S_AIM:    if (frame_tick && fcnt == FCNT_W'(AIM_FRAMES - 1)) state_d = S_FLIGHT;
            S_FLIGHT: if (frame_tick && fcnt == FCNT_W'(FLIGHT_FRAMES - 1)) state_d = S_JUDGE;
            S_JUDGE:  state_d = S_RESULT;
            S_RESULT: begin
                if (frame_tick && fcnt == FCNT_W'(RESULT_FRAMES - 1)) begin
                    state_d = (shot_num == 4'(SHOTS_PER_MATCH)) ? S_DONE : S_AIM;
                end
            end
            S_DONE:   if (start) state_d = S_AIM;
            default:  state_d = S_IDLE;
        endcase
    end

    assign aim_entry = (state_d == S_AIM) && (state != S_AIM);

    // Frame timer restarts on every state change; a tick on the entry cycle counts
    always_ff @(posedge clk) begin
        if (rst)                  fcnt <= '0;
        else if (state_d != state) fcnt <= '0;
        else if (frame_tick)      fcnt <= fcnt + FCNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr        <= LFSR_SEED;
            shot_xpos   <= '0;
            shot_ypos   <= '0;
            glove_x     <= '0;
            glove_y     <= '0;
            ball_launch <= 1'b0;
            ball_active <= 1'b0;
            goal_pulse  <= 1'b0;
            save_pulse  <= 1'b0;
            result_show <= 1'b0;
            goals       <= '0;
            saves       <= '0;
            shot_num    <= '0;
            match_over  <= 1'b0;
            player_won  <= 1'b0;
`ifdef MISS_SHOTS_EN
            shot_miss   <= 1'b0;
`endif
        end else begin
            lfsr        <= lfsr_next;
            ball_launch <= (state == S_AIM) && (state_d == S_FLIGHT);
            ball_active <= (state_d == S_FLIGHT);
            result_show <= (state_d == S_RESULT);
            match_over  <= (state_d == S_DONE);
            goal_pulse  <= 1'b0;
            save_pulse  <= 1'b0;

            // New shot: pick target; a fresh match also clears the score
            if (aim_entry) begin
                shot_xpos <= 12'(X_MIN) + 12'(lfsr[8:0]);
                shot_ypos <= 12'(Y_MIN) + 12'(lfsr[15:9]);
`ifdef MISS_SHOTS_EN
                shot_miss <= 1'b0;
                if (lfsr[3:0] == 4'd0) begin
                    shot_xpos <= 12'(X_MIN - 32);
                    shot_miss <= 1'b1;
                end
`endif
                if (state == S_RESULT) begin
                    shot_num <= shot_num + 4'd1;
                end else begin
                    shot_num <= 4'd1;
                    goals    <= '0;
                    saves    <= '0;
                end
            end

            if (state == S_FLIGHT && state_d == S_JUDGE) begin
                glove_x <= xpos;
                glove_y <= ypos;
            end

            if (state == S_JUDGE) begin
                if (judge_save) begin
                    save_pulse <= 1'b1;
                    saves      <= saves + 4'd1;
                end else begin
                    goal_pulse <= 1'b1;
                    goals      <= goals + 4'd1;
                end
            end

            if (state == S_RESULT && state_d == S_DONE) player_won <= (saves > goals);
            else if (state_d != S_DONE)                 player_won <= 1'b0;
        end
    end

endmodule

// File: tb/tb_penalty_round_ctl.sv
// Scoreboard bench for penalty_round_ctl with short frame timings (aim 2, flight 3, result 1).
module tb_penalty_round_ctl;

    localparam int unsigned AIM_F  = 2;
    localparam int unsigned FLT_F  = 3;
    localparam int unsigned RES_F  = 1;
    localparam int unsigned SHOTS  = 5;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        start;
    logic [11:0] xpos, ypos;
    logic [11:0] shot_xpos, shot_ypos;
    logic        ball_launch, ball_active, goal_pulse, save_pulse, result_show;
    logic [3:0]  goals, saves, shot_num;
    logic        match_over, player_won;

    penalty_round_ctl #(
        .SHOTS_PER_MATCH(SHOTS),
        .AIM_FRAMES     (AIM_F),
        .FLIGHT_FRAMES  (FLT_F),
        .RESULT_FRAMES  (RES_F)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .xpos       (xpos),
        .ypos       (ypos),
        .shot_xpos  (shot_xpos),
        .shot_ypos  (shot_ypos),
        .ball_launch(ball_launch),
        .ball_active(ball_active),
        .goal_pulse (goal_pulse),
        .save_pulse (save_pulse),
        .result_show(result_show),
        .goals      (goals),
        .saves      (saves),
        .shot_num   (shot_num),
        .match_over (match_over),
        .player_won (player_won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];
    int exp_s, exp_g;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Reference LFSR; m_prev is the value the DUT saw before the latest edge
    logic [15:0] m_lfsr, m_prev;
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lfsr_step(m_lfsr);
        m_prev <= m_lfsr;
    end

    // Frame tick every third cycle
    initial begin
        int cyc;
        cyc = 0;
        frame_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            frame_tick = (cyc % 3 == 0);
        end
    end

    // Monitor: phase timing, target positions and scoreboard pops
    logic [3:0] prev_sn;
    bit  in_aim, prev_ba, prev_rs, prev_mo;
    int  aim_cnt, fl_cnt, rs_cnt, m_saves, m_goals;
    initial begin
        prev_sn = 0; in_aim = 0; prev_ba = 0; prev_rs = 0; prev_mo = 0;
        aim_cnt = 0; fl_cnt = 0; rs_cnt = 0; m_saves = 0; m_goals = 0;
    end

    always @(negedge clk) begin
        logic [11:0] ex;
        bit e;
        if (rst) begin
            prev_sn = 0; in_aim = 0; prev_ba = 0; prev_rs = 0; prev_mo = 0;
            aim_cnt = 0; fl_cnt = 0; rs_cnt = 0; m_saves = 0; m_goals = 0;
        end else begin
            if (shot_num != prev_sn && shot_num != 0) begin
                if (shot_num == 1) begin
                    m_saves = 0;
                    m_goals = 0;
                end
                ex = 12'd256 + 12'(m_prev[8:0]);
`ifdef MISS_SHOTS_EN
                if (m_prev[3:0] == 4'd0) ex = 12'd224;
`endif
                chk("shot_xpos", int'(shot_xpos), int'(ex));
                chk("shot_ypos", int'(shot_ypos), 160 + int'(m_prev[15:9]));
                in_aim  = 1;
                aim_cnt = int'(frame_tick);
            end else if (ball_launch) begin
                chk("aim_ticks", aim_cnt, AIM_F);
                chk("launch_active", int'(ball_active), 1);
                in_aim = 0;
            end else if (in_aim) begin
                aim_cnt += int'(frame_tick);
            end

            if (ball_active) fl_cnt += int'(frame_tick);
            else if (prev_ba) begin
                chk("flight_ticks", fl_cnt, FLT_F);
                fl_cnt = 0;
            end

            if (result_show) rs_cnt += int'(frame_tick);
            else if (prev_rs) begin
                chk("result_ticks", rs_cnt, RES_F);
                rs_cnt = 0;
            end

            if (goal_pulse || save_pulse) begin
                chk("one_pulse", int'(goal_pulse & save_pulse), 0);
                chk("pulse_in_result", int'(result_show), 1);
                if (exp_q.size() == 0) begin
                    chk("pulse_expected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("outcome_save", int'(save_pulse), int'(e));
                    if (e) m_saves++;
                    else   m_goals++;
                end
                chk("saves", int'(saves), m_saves);
                chk("goals", int'(goals), m_goals);
                chk("tally", int'(saves) + int'(goals), int'(shot_num));
            end

            if (match_over && !prev_mo) begin
                chk("player_won", int'(player_won), int'(m_saves > m_goals));
                chk("final_shot_num", int'(shot_num), SHOTS);
                chk("queue_drained", exp_q.size(), 0);
            end

            prev_sn = shot_num;
            prev_ba = ball_active;
            prev_rs = result_show;
            prev_mo = match_over;
        end
    end

    task automatic tick_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_match();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_s = 0;
        exp_g = 0;
    endtask

    task automatic wait_launch(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ball_launch) begin
                ok = 1;
                break;
            end
        end
        chk("launch_seen", int'(ok), 1);
    endtask

    task automatic wait_over();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (match_over) begin
                ok = 1;
                break;
            end
        end
        chk("match_over_seen", int'(ok), 1);
    endtask

    // Place the glove for the shot now in flight and record the expected outcome
    task automatic run_shot(input bit abs_pos, input int gx, input int gy, input bit exp_save);
        bit ok, e;
        wait_launch(ok);
        if (ok) begin
            e = exp_save;
`ifdef MISS_SHOTS_EN
            if (shot_xpos == 12'd224) e = 1'b1;
`endif
            exp_q.push_back(e);
            if (e) exp_s++;
            else   exp_g++;
            @(posedge clk); #1;
            xpos = abs_pos ? 12'(gx) : 12'(int'(shot_xpos) + gx);
            ypos = abs_pos ? 12'(gy) : 12'(int'(shot_ypos) + gy);
        end
    endtask

    initial begin
        bit any_nz;
        bit ok;
        rst = 1'b1; start = 1'b0; xpos = '0; ypos = '0;
        tick_cycles(2);
        rst = 1'b0;

        // Reset values then a long quiet idle
        @(negedge clk);
        chk("rst_scores", int'({goals, saves, shot_num}), 0);
        chk("rst_flags", int'({ball_launch, ball_active, goal_pulse, save_pulse,
                               result_show, match_over, player_won}), 0);
        chk("rst_shot_pos", int'({shot_xpos, shot_ypos}), 0);
        any_nz = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            any_nz |= |{shot_xpos, shot_ypos, ball_launch, ball_active, goal_pulse, save_pulse,
                        result_show, goals, saves, shot_num, match_over, player_won};
        end
        chk("idle_quiet", int'(any_nz), 0);

        // Perfect keeper
        start_match();
        for (int s = 0; s < 5; s++) run_shot(1'b0, 0, 0, 1'b1);
        wait_over();
        chk("m1_saves", int'(saves), 5);
        chk("m1_goals", int'(goals), 0);
        chk("m1_won", int'(player_won), 1);

        // Absent keeper, restarted from the finished match
        xpos = '0; ypos = '0;
        start_match();
        for (int s = 0; s < 5; s++) run_shot(1'b1, 0, 0, 1'b0);
        wait_over();
        chk("m2_goals", int'(goals), exp_g);
        chk("m2_saves", int'(saves), exp_s);
        chk("m2_won", int'(player_won), int'(exp_s > exp_g));

        // Tolerance edges: +64 save, +65 goal, -48 save, -49 goal, corner save
        start_match();
        run_shot(1'b0,  64,   0, 1'b1);
        run_shot(1'b0,  65,   0, 1'b0);
        run_shot(1'b0,   0, -48, 1'b1);
        run_shot(1'b0,   0, -49, 1'b0);
        run_shot(1'b0, -64,  48, 1'b1);
        wait_over();
        chk("m3_saves", int'(saves), exp_s);
        chk("m3_goals", int'(goals), exp_g);
        chk("m3_won", int'(player_won), 1);

        // Reset during flight of shot 3
        start_match();
        run_shot(1'b0, 0, 0, 1'b1);
        run_shot(1'b1, 0, 0, 1'b0);
        wait_launch(ok);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_scores", int'({goals, saves, shot_num}), 0);
        chk("midrst_flags", int'({ball_launch, ball_active, goal_pulse, save_pulse,
                                  result_show, match_over, player_won}), 0);
        tick_cycles(12);
        @(negedge clk);
        chk("midrst_stays_idle", int'({ball_active, result_show, shot_num}), 0);

        start_match();
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (shot_num != 0) begin
                ok = 1;
                break;
            end
        end
        chk("restart_shot_num", int'(shot_num), 1);
        chk("restart_scores", int'({goals, saves}), 0);
        for (int s = 0; s < 5; s++) run_shot(1'b0, 10, -10, 1'b1);
        wait_over();
        chk("m4_saves", int'(saves), exp_s);
        chk("m4_won", int'(player_won), 1);

        tick_cycles(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/penalty_round_ctl.md
Name: penalty_round_ctl

Overview:
- Sequences single-player penalty rounds: CPU shoots, player keeps goal with the mouse-driven gloves.
- Per shot: picks a pseudo-random target, runs aim, flight and result phases timed in frames, judges save vs goal against the glove position, keeps the score, and declares the match result.
- Sits between game state selection and the gloves/ball drawing blocks; drives the ball-control shot position and launch.

Parameters:
- SHOTS_PER_MATCH, 5, shots per match (1..15).
- AIM_FRAMES, 60, frames between target pick and launch (>=1).
- FLIGHT_FRAMES, 30, frames of ball flight (>=1).
- RESULT_FRAMES, 90, frames the shot result is held (>=1).
- X_MIN, 256, left edge of target area; x span fixed at 512 px.
- Y_MIN, 160, top edge of target area; y span fixed at 128 px.
- GLOVE_HALF_W, 64, horizontal save tolerance in px.
- GLOVE_HALF_H, 48, vertical save tolerance in px.
- LFSR_SEED, 16'hACE1, LFSR reset value (nonzero).

Ports:
- clk  in  1  system clock (single clock domain).
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  begin match (sampled in IDLE and DONE).
- xpos  in  12  glove (mouse) x.
- ypos  in  12  glove (mouse) y.
- shot_xpos  out  12  target x of current shot.
- shot_ypos  out  12  target y of current shot.
- ball_launch  out  1  one-cycle pulse at flight start.
- ball_active  out  1  high during FLIGHT.
- goal_pulse  out  1  one-cycle pulse, shot scored.
- save_pulse  out  1  one-cycle pulse, shot saved or missed.
- result_show  out  1  high during RESULT.
- goals  out  4  goals conceded.
- saves  out  4  saves plus misses.
- shot_num  out  4  shots started this match (1-based while a shot is active).
- match_over  out  1  high in DONE.
- player_won  out  1  valid when match_over; 1 if saves > goals.

Behaviour:
- Reset: state IDLE; every output 0; LFSR = LFSR_SEED; frame counter 0.
- LFSR: 16-bit Galois, taps 16,14,13,11; advances every clk, including during reset release; never zero.
- States and transitions (all timers count frame_tick only, counter cleared on each state entry):
  - IDLE: start -> AIM; clears goals, saves and shot_num.
  - AIM: on the entry cycle, latch shot_xpos = X_MIN + lfsr[8:0] and shot_ypos = Y_MIN + lfsr[15:9]; increment shot_num. After AIM_FRAMES ticks -> FLIGHT, with ball_launch high on the transition cycle.
  - FLIGHT: ball_active = 1. On the FLIGHT_FRAMES-th tick, sample xpos/ypos and go to JUDGE.
  - JUDGE (1 cycle): save if |xpos - shot_xpos| <= GLOVE_HALF_W and |ypos - shot_ypos| <= GLOVE_HALF_H. Differences computed in 13-bit signed, no wrap. Save -> save_pulse, saves+1; otherwise goal_pulse, goals+1. Pulses are registered and appear on the cycle JUDGE exits. -> RESULT.
  - RESULT: result_show = 1. After RESULT_FRAMES ticks: shot_num == SHOTS_PER_MATCH -> DONE, else -> AIM.
  - DONE: match_over = 1; player_won = (saves > goals), latched on entry. start -> AIM with scores cleared and shot_num = 1.
- shot_xpos/shot_ypos are held stable from AIM entry through RESULT.
- A frame_tick on the state-entry cycle counts toward that state's timer.
- start is ignored outside IDLE and DONE.
- goals + saves == shot_num after every JUDGE.
- Counters never exceed SHOTS_PER_MATCH.
- rst in any state returns to IDLE within one cycle and kills any in-flight pulse.

Optional Feature:
- Macro: MISS_SHOTS_EN.
- Defined: in AIM entry, if lfsr[3:0] == 0, the shot is a miss. shot_xpos is forced to X_MIN - 32 and the shot is flagged. JUDGE treats a flagged shot as a save (save_pulse, saves+1) regardless of glove position.
- Undefined: targets always lie inside the target area; there is no miss path.

Test Plan:
- Reset then idle: rst 1 for 2 clk, frame_tick running, no start -> all outputs 0, state stays IDLE for 200 frames.
- Perfect keeper: start; each FLIGHT, xpos/ypos = latched shot_xpos/shot_ypos -> 5 save_pulse, saves=5, goals=0, match_over=1, player_won=1.
- Absent keeper: xpos=0, ypos=0 throughout (MISS_SHOTS_EN off) -> 5 goal_pulse, goals=5, player_won=0.
- Tolerance edges: glove at shot_xpos+64 -> save; at +65 -> goal; at ypos offset -48 -> save, -49 -> goal.
- Timing: AIM_FRAMES=2, FLIGHT_FRAMES=3, RESULT_FRAMES=1 -> ball_launch exactly on the 2nd tick after AIM entry; ball_active for 3 ticks; result_show for 1 tick.
- Reset mid-flight: assert rst during FLIGHT of shot 3 -> next cycle IDLE, scores 0; a fresh start gives shot_num=1.
